req_ack_rr_arbiter: RTL and testbench
=====================================

Name: req_ack_rr_arbiter

Overview:
- Shares one req/ack-handshake resource among N requesters using round-robin arbitration.
- Each requester raises a level `req` and receives a one-cycle `ack` when the resource completes.
- The arbiter drives the resource's single `res_req` and waits for `res_ack`, with a bounded timeout.
- Sits between requester blocks and the shared resource; the resource's own req/ack protocol is unchanged.

Parameters:
- N, 4, number of requesters (2..16).
- TIMEOUT, 8, max cycles `res_req` stays high awaiting `res_ack` (≥2).
- IDW, $clog2(N), width of granted index.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester level request.
- ack  output  N  per-requester one-cycle completion pulse.
- gnt  output  N  one-hot current owner; 0 when idle.
- gnt_id  output  IDW  binary index of owner; valid while busy=1.
- res_req  output  1  request to shared resource.
- res_ack  input  1  resource completion.
- busy  output  1  high in WAIT and RELEASE.
- timeout_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE; ack, gnt, gnt_id, res_req, busy, timeout_err = 0; priority pointer last=N-1, so requester 0 is highest after reset; timeout counter=0.
- States: IDLE, WAIT, RELEASE.
- IDLE:
  - If req≠0, pick the first set bit searching from (last+1) mod N upward with wrap.
  - At that edge: gnt=onehot(pick), gnt_id=pick, res_req=1, busy=1, cnt=0, go to WAIT.
  - Latency: req sampled high at edge k gives res_req/gnt high after edge k.
  - req=0: stay IDLE.
- WAIT:
  - res_req held high; cnt increments each cycle.
  - res_ack=1: res_req=0, ack[gnt_id]=1 for one cycle, last=gnt_id, go to RELEASE.
  - Else if cnt==TIMEOUT-1: res_req=0, timeout_err=1 for one cycle, no ack, last=gnt_id, go to RELEASE.
  - res_ack and timeout on the same edge: res_ack wins; no error.
  - Owner dropping req during WAIT does not abort; the transaction completes and ack still pulses.
- RELEASE:
  - Exactly one cycle: gnt=0, busy=0 at exit, then IDLE.
  - Guarantees res_req is low for ≥1 cycle between transactions (two cycles including the IDLE evaluation cycle).
  - A requester still holding req is re-arbitrated with lowest priority.
- res_ack outside WAIT is ignored.
- At most one ack bit is set per cycle; ack and timeout_err are never set together.
- gnt is always one-hot or zero.
- Fairness: any continuously asserted req is granted within N transactions.
- cnt width is $clog2(TIMEOUT); it never wraps because it is cleared on WAIT entry.

Optional Feature:
- Macro: REQ_ACK_ARB_SVA_EN.
- Defined: embedded concurrent assertions on default clocking @(posedge clk), disabled iff rst. Each failure reports via $error with $time.
  - gnt is one-hot-or-zero.
  - res_req |-> gnt≠0.
  - ack[i] |-> $past(gnt[i]).
  - ack is never 2+ bits.
  - ack and timeout_err are mutually exclusive.
  - res_req falls ⇒ res_req low for the following cycle.
  - req[i] held high ⇒ ack[i] or timeout_err within N*(TIMEOUT+2) cycles.
  - Cover properties: back-to-back grants, timeout, simultaneous all-req.
- Undefined: no assertions compiled; RTL behaviour identical.

Decomposition:
- Package req_ack_arb_pkg:
  - state enum (IDLE, WAIT, RELEASE), 2-bit.
  - localparam defaults N_DEF=4, TIMEOUT_DEF=8.
  - Function onehot(idx, n).
- Sub-module rr_picker:
  - Combinational rotate-priority encoder.
  - Inputs: req[N], last[IDW].
  - Outputs: pick[IDW], valid.
  - Instantiated once in the arbiter.

Test Plan:
- Reset mid-WAIT: req=4'b0001, assert rst 2 cycles into WAIT → res_req, gnt, busy drop immediately (async). After release, req=4'b0010 → requester 1 granted.
- Round-robin: N=4, req=4'b1111 held, res_ack returns 3 cycles after each res_req → grant order 0,1,2,3,0. ack pulses one cycle each; res_req low ≥1 cycle between grants.
- Timeout: TIMEOUT=8, req=4'b0100, res_ack never → res_req high exactly 8 cycles, timeout_err pulses once, ack stays 0. Next grant goes to requester 3 if req[3]=1.
- Tie at timeout: res_ack asserted on the 8th WAIT cycle → ack[gnt_id]=1, timeout_err=0.
- Stray/early events: res_ack pulsed in IDLE → no ack, no state change. Owner drops req during WAIT, then res_ack → ack still pulses.
- Single requester streaming: req=4'b0001 held, res_ack 1 cycle after res_req → repeated grants to 0 with 3-cycle period, fairness assertion passes.

Source files
------------

// File: rtl/req_ack_arb_pkg.sv
// -----------------------------------------------------------------------------
// req_ack_arb_pkg
// Shared types and helpers for the round-robin req/ack arbiter.
//   state_e     : arbiter FSM state (IDLE, WAIT, RELEASE), 2-bit encoding
//   N_DEF       : default requester count
//   TIMEOUT_DEF : default resource timeout in cycles
//   MAX_N       : largest supported requester count
//   onehot()    : index -> one-hot vector (zero when idx >= n)
// -----------------------------------------------------------------------------
package req_ack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int N_DEF       = 4;
  localparam int TIMEOUT_DEF = 8;
  localparam int MAX_N       = 16;

  function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx, input int n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (int'(idx) < n) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational rotating-priority encoder. The search starts one position
// after `last` and wraps, so the most recent owner gets lowest priority.
// Ports:
//   req   [N]   : request vector
//   last  [IDW] : index of the previous owner
//   pick  [IDW] : selected requester (0 when none)
//   valid       : at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] pick,
  output logic           valid
);

  int idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    // i runs 1..N so `last` itself is visited last.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!valid && req[IDW'(idx)]) begin
        valid = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/req_ack_rr_arbiter.sv
// -----------------------------------------------------------------------------
// req_ack_rr_arbiter
// Shares one req/ack resource among N requesters with round-robin priority
// and a bounded wait for the resource's acknowledge.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   req   [N]   : per-requester level request
//   ack   [N]   : one-cycle completion pulse to the owner
//   gnt   [N]   : one-hot current owner, zero when idle
//   gnt_id[IDW] : binary owner index, meaningful while busy
//   res_req     : request to the shared resource
//   res_ack     : resource completion (ignored outside WAIT)
//   busy        : high in WAIT and RELEASE
//   timeout_err : one-cycle pulse when a transaction is aborted
// Optional: define REQ_ACK_ARB_SVA_EN to compile embedded assertions/covers.
// -----------------------------------------------------------------------------
module req_ack_rr_arbiter
  import req_ack_arb_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           res_req,
  input  logic           res_ack,
  output logic           busy,
  output logic           timeout_err
);

  localparam int              CNTW    = $clog2(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            res_req_q, res_req_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            timeout_err_q, timeout_err_d;

  logic [IDW-1:0]  pick;
  logic            pick_valid;

  rr_picker #(.N(N), .IDW(IDW)) u_picker (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    gnt_id_d      = gnt_id_q;
    res_req_d     = res_req_q;
    busy_d        = busy_q;
    ack_d         = '0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d     = N'(onehot(4'(pick), N));
          gnt_id_d  = pick;
          res_req_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // res_ack is tested first so a same-edge timeout never raises an error.
        if (res_ack) begin
          res_req_d = 1'b0;
          ack_d     = gnt_q;
          last_d    = gnt_id_q;
          state_d   = RELEASE;
        end else if (cnt_q == CNT_MAX) begin
          res_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          last_d        = gnt_id_q;
          state_d       = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // Holding one extra cycle guarantees a res_req low gap before re-grant.
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= IDW'(N - 1);
      cnt_q         <= '0;
      gnt_q         <= '0;
      gnt_id_q      <= '0;
      res_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      gnt_id_q      <= gnt_id_d;
      res_req_q     <= res_req_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ack         = ack_q;
  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign res_req     = res_req_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

`ifdef REQ_ACK_ARB_SVA_EN
  localparam int FAIR_BOUND = N * (TIMEOUT + 2);

  default clocking cb @(posedge clk);
  endclocking

  a_gnt_onehot: assert property (disable iff (rst) $onehot0(gnt))
    else $error("gnt not one-hot-or-zero at %0t", $time);
  a_req_has_gnt: assert property (disable iff (rst) res_req |-> (gnt != '0))
    else $error("res_req without owner at %0t", $time);
  a_ack_onehot: assert property (disable iff (rst) $onehot0(ack))
    else $error("multiple ack bits at %0t", $time);
  a_ack_to_excl: assert property (disable iff (rst) !((ack != '0) && timeout_err))
    else $error("ack and timeout_err together at %0t", $time);
  a_res_gap: assert property (disable iff (rst) $fell(res_req) |=> !res_req)
    else $error("res_req gap violated at %0t", $time);

  for (genvar i = 0; i < N; i++) begin : g_sva
    a_ack_owner: assert property (disable iff (rst) ack[i] |-> $past(gnt[i]))
      else $error("ack[%0d] without prior grant at %0t", i, $time);
    a_fair: assert property (disable iff (rst)
      req[i] |-> ##[0:FAIR_BOUND] (ack[i] || timeout_err || !req[i]))
      else $error("req[%0d] starved at %0t", i, $time);
  end

  c_back_to_back: cover property (disable iff (rst) $fell(busy) ##1 busy);
  c_timeout:      cover property (disable iff (rst) timeout_err);
  c_all_req:      cover property (disable iff (rst) (&req) && !busy);
`endif

endmodule

// File: tb/tb_req_ack_rr_arbiter.sv
module tb_req_ack_rr_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 8;
  localparam int IDW     = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   ack;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           res_req;
  logic           res_ack;
  logic           busy;
  logic           timeout_err;

  req_ack_rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .res_req     (res_req),
    .res_ack     (res_ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: who owns the resource, how long it has waited,
  // and whether its transaction has finished (release cycle).
  // ---------------------------------------------------------------------------
  int         m_owner = -1;
  int         m_last  = N - 1;
  int         m_age   = 0;
  bit         m_done  = 1'b0;
  logic [N-1:0] m_ack = '0;
  bit         m_to    = 1'b0;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_age = 0; m_done = 1'b0; m_ack = '0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic ra);
    int c;
    bit found;
    m_ack = '0;
    m_to  = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (!found && r[c]) begin
          found = 1'b1;
          m_owner = c;
        end
      end
      m_age  = 0;
      m_done = 1'b0;
    end else if (!m_done) begin
      if (ra) begin
        m_ack[m_owner] = 1'b1;
        m_done = 1'b1;
        m_last = m_owner;
      end else if (m_age == TIMEOUT - 1) begin
        m_to   = 1'b1;
        m_done = 1'b1;
        m_last = m_owner;
      end else begin
        m_age++;
      end
    end else begin
      m_owner = -1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step(req, res_ack);
    end
  end

  // ---------------------------------------------------------------------------
  // Compare against the model and keep event counters / grant log.
  // ---------------------------------------------------------------------------
  typedef struct { int id; int cyc; } gl_t;
  gl_t  glog[$];
  int   cyc = 0;
  int   rr_high = 0;
  int   ack_cnt = 0;
  int   to_cnt = 0;
  logic [N-1:0] ack_seen = '0;
  logic prev_rr = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check("gnt",         32'(gnt),         (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("busy",        32'(busy),        32'(m_owner >= 0));
      check("res_req",     32'(res_req),     32'((m_owner >= 0) && !m_done));
      check("ack",         32'(ack),         32'(m_ack));
      check("timeout_err", 32'(timeout_err), 32'(m_to));
      if (m_owner >= 0) check("gnt_id", 32'(gnt_id), 32'(m_owner));
      if (res_req && !prev_rr) glog.push_back('{id: int'(gnt_id), cyc: cyc});
      rr_high += int'(res_req);
      ack_cnt += $countones(ack);
      to_cnt  += int'(timeout_err);
      if (ack != '0) ack_seen = ack;
      prev_rr = res_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Resource responder: res_ack `resp_delay` cycles after res_req rises
  // (0 = never), plus a test-controlled stray pulse.
  // ---------------------------------------------------------------------------
  int resp_delay = 0;
  bit stray = 1'b0;
  int age = 0;

  initial begin
    res_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (res_req) age++;
      else age = 0;
      res_ack = stray || (resp_delay > 0 && age == resp_delay);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (glog.size() < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, 32'(glog.size() >= target), 32'd1);
    @(posedge clk);
    #1;
  endtask

  int base, a0, t0, r0;
  int exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    req = '0;
    tick(2);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Round robin with all requesting, res_ack 3 cycles after res_req.
    resp_delay = 3;
    base = glog.size(); a0 = ack_cnt;
    req = 4'b1111;
    wait_log(base + 5, 200, "rr_wait");
    req = '0;
    tick(12);
    for (int i = 0; i < 5; i++) check("rr_order", 32'(glog[base + i].id), 32'(exp_rr[i]));
    for (int i = 1; i < 5; i++) check("rr_period", 32'(glog[base + i].cyc - glog[base + i - 1].cyc), 32'd5);
    check("rr_acks", 32'(ack_cnt - a0), 32'd5);

    // Timeout: no res_ack; requester 2 then requester 3.
    resp_delay = 0;
    base = glog.size(); a0 = ack_cnt; t0 = to_cnt; r0 = rr_high;
    req = 4'b1100;
    wait_log(base + 2, 100, "to_wait");
    req = '0;
    tick(14);
    check("to_first", 32'(glog[base].id), 32'd2);
    check("to_second", 32'(glog[base + 1].id), 32'd3);
    check("to_rr_high", 32'(rr_high - r0), 32'd16);
    check("to_pulses", 32'(to_cnt - t0), 32'd2);
    check("to_no_ack", 32'(ack_cnt - a0), 32'd0);

    // Tie: res_ack on the 8th WAIT cycle.
    resp_delay = 8;
    base = glog.size(); a0 = ack_cnt; t0 = to_cnt;
    req = 4'b0001;
    wait_log(base + 1, 50, "tie_wait");
    req = '0;
    tick(14);
    check("tie_id", 32'(glog[base].id), 32'd0);
    check("tie_ack", 32'(ack_cnt - a0), 32'd1);
    check("tie_no_err", 32'(to_cnt - t0), 32'd0);

    // Stray res_ack while idle.
    base = glog.size(); a0 = ack_cnt;
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    tick(3);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_ack", 32'(ack_cnt - a0), 32'd0);
    check("stray_nogrant", 32'(glog.size()), 32'(base));

    // Owner drops req during WAIT; ack still delivered.
    resp_delay = 4;
    base = glog.size(); a0 = ack_cnt;
    req = 4'b0010;
    wait_log(base + 1, 50, "drop_wait");
    req = '0;
    tick(10);
    check("drop_id", 32'(glog[base].id), 32'd1);
    check("drop_ack", 32'(ack_cnt - a0), 32'd1);
    check("drop_ack_bit", 32'(ack_seen), 32'b0010);

    // Asynchronous reset two cycles into WAIT.
    resp_delay = 0;
    base = glog.size();
    req = 4'b0001;
    wait_log(base + 1, 50, "rst_wait");
    tick(1);
    rst = 1'b1;
    #1;
    check("rst_res_req", 32'(res_req), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req = '0;
    tick(2);
    rst = 1'b0;
    resp_delay = 2;
    base = glog.size();
    req = 4'b0010;
    wait_log(base + 1, 50, "post_rst_wait");
    req = '0;
    tick(8);
    check("post_rst_id", 32'(glog[base].id), 32'd1);

    // Single requester streaming with res_ack one cycle after res_req.
    resp_delay = 1;
    base = glog.size();
    req = 4'b0001;
    wait_log(base + 4, 50, "stream_wait");
    req = '0;
    tick(8);
    for (int i = 0; i < 4; i++) check("stream_id", 32'(glog[base + i].id), 32'd0);
    for (int i = 1; i < 4; i++) check("stream_period", 32'(glog[base + i].cyc - glog[base + i - 1].cyc), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
